// File: rtl/tick_mod_counter.sv
// Programmable tick divider (CLK_HZ/TICK_HZ) driving a modulo-MOD up/down counter with display digits.
// Define TICK_MOD_COUNTER_BCD_EN for decimal digits; the default build emits hex digits.
module tick_mod_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 30,
    parameter int MOD     = 30,
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             up,
    input  logic             sclear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic [3:0]       digit_lo,
    output logic [3:0]       digit_hi
);

    localparam int DIVISOR = CLK_HZ / TICK_HZ;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MOD - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("tick_mod_counter: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (MOD < 2 || MOD > 256 || (2.0 ** CNT_W) < MOD) begin : g_bad_mod
        $error("tick_mod_counter: MOD out of range for CNT_W");
    end
    if ((2.0 ** DIV_W) < DIVISOR) begin : g_bad_div_w
        $error("tick_mod_counter: DIV_W too narrow for DIVISOR");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       digit_lo_q, digit_lo_d;
    logic [3:0]       digit_hi_q, digit_hi_d;
    logic             div_last;

    assign div_last = (div_q == DIV_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_d   = div_last ? '0 : div_q + DIV_W'(1);
        tick_d  = div_last && !sclear;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (sclear) begin
            div_d   = '0;
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (div_last && enable) begin
            if (up) begin
                if (count_q == MAX_CNT) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_CNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

`ifdef TICK_MOD_COUNTER_BCD_EN
    if (MOD > 100) begin : g_bcd_mod_check
        $error("tick_mod_counter: decimal digits require MOD <= 100");
    end

    logic [31:0] count_wide;
    assign count_wide = 32'(count_d);

    always_comb begin
        digit_lo_d = 4'(count_wide % 32'd10);
        digit_hi_d = 4'((count_wide / 32'd10) % 32'd10);
    end
`else
    // Zero-extends narrow counts and drops bits above 7 on wide ones.
    logic [7:0] count_byte;
    assign count_byte = 8'(count_d);

    always_comb begin
        digit_lo_d = count_byte[3:0];
        digit_hi_d = count_byte[7:4];
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            digit_lo_q <= '0;
            digit_hi_q <= '0;
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            digit_lo_q <= digit_lo_d;
            digit_hi_q <= digit_hi_d;
        end
    end

    assign tick     = tick_q;
    assign count    = count_q;
    assign wrap     = wrap_q;
    assign digit_lo = digit_lo_q;
    assign digit_hi = digit_hi_q;

endmodule

// File: tb/tb_tick_mod_counter.sv
// Scoreboard bench for tick_mod_counter: a per-edge reference model queues expected outputs,
// a monitor pops and compares them after each clock edge.
module tb_tick_mod_counter;

    localparam int CLK_HZ  = 60;
    localparam int TICK_HZ = 10;
    localparam int MOD     = 12;
    localparam int DIV_W   = 4;
    localparam int CNT_W   = 8;
    localparam int DIVISOR = CLK_HZ / TICK_HZ;

    logic             clock = 1'b0;
    logic             resetn;
    logic             enable;
    logic             up;
    logic             sclear;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic [3:0]       digit_lo;
    logic [3:0]       digit_hi;

    tick_mod_counter #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .MOD    (MOD),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .enable  (enable),
        .up      (up),
        .sclear  (sclear),
        .load    (load),
        .load_val(load_val),
        .tick    (tick),
        .count   (count),
        .wrap    (wrap),
        .digit_lo(digit_lo),
        .digit_hi(digit_hi)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       tick;
        logic [7:0] count;
        logic       wrap;
        logic [3:0] dlo;
        logic [3:0] dhi;
    } resp_t;

    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: clocks elapsed since the last clear, and the count as an integer.
    int m_phase = 0;
    int m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, input logic u, input logic scl, input logic ld,
                              input logic [7:0] lv, output resp_t r);
        bit tick_cond;
        bit w;
        int nxt;
        tick_cond = (m_phase == DIVISOR - 1);
        w         = 1'b0;
        nxt       = m_count;
        if (scl) begin
            nxt = 0;
        end else if (ld) begin
            nxt = (int'(lv) > MOD - 1) ? MOD - 1 : int'(lv);
        end else if (tick_cond && en) begin
            if (u) begin
                nxt = (m_count + 1) % MOD;
                w   = (m_count + 1 == MOD);
            end else begin
                nxt = (m_count + MOD - 1) % MOD;
                w   = (m_count == 0);
            end
        end
        m_phase = scl ? 0 : (m_phase + 1) % DIVISOR;
        m_count = nxt;
        r.tick  = tick_cond && !scl;
        r.count = 8'(nxt);
        r.wrap  = w;
`ifdef TICK_MOD_COUNTER_BCD_EN
        r.dlo = 4'(nxt % 10);
        r.dhi = 4'((nxt / 10) % 10);
`else
        r.dlo = 4'(nxt % 16);
        r.dhi = 4'(nxt / 16);
`endif
    endtask

    task automatic drive_and_push(input logic en, input logic u, input logic scl, input logic ld,
                                  input logic [7:0] lv);
        resp_t r;
        enable   = en;
        up       = u;
        sclear   = scl;
        load     = ld;
        load_val = lv;
        model_edge(en, u, scl, ld, lv, r);
        exp_q.push_back(r);
    endtask

    task automatic step(input logic en, input logic u, input logic scl, input logic ld,
                        input logic [7:0] lv);
        @(negedge clock);
        drive_and_push(en, u, scl, ld, lv);
    endtask

    task automatic run_to_tick_edge(input logic en, input logic u);
        int guard;
        guard = 0;
        while (m_phase != DIVISOR - 1 && guard < 4 * DIVISOR) begin
            step(en, u, 1'b0, 1'b0, 8'd0);
            guard++;
        end
        check("tick_edge_reached", 32'(m_phase), 32'(DIVISOR - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, 32'(tick), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_wrap"}, 32'(wrap), 32'd0);
        check({tag, "_digit_lo"}, 32'(digit_lo), 32'd0);
        check({tag, "_digit_hi"}, 32'(digit_hi), 32'd0);
    endtask

    // Monitor: compares the outputs one step after every edge that had stimulus queued.
    initial begin
        resp_t e;
        logic  prev_wrap;
        prev_wrap = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", 32'(tick), 32'(e.tick));
                check("count", 32'(count), 32'(e.count));
                check("wrap", 32'(wrap), 32'(e.wrap));
                check("digit_lo", 32'(digit_lo), 32'(e.dlo));
                check("digit_hi", 32'(digit_hi), 32'(e.dhi));
                if (wrap) check("wrap_single_cycle", 32'(prev_wrap), 32'd0);
            end
            prev_wrap = wrap;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the run finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       up_r;
        logic [7:0] lv_r;
        resetn   = 1'b0;
        enable   = 1'b0;
        up       = 1'b1;
        sclear   = 1'b0;
        load     = 1'b0;
        load_val = '0;

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset_state");

        // Count up from reset: ticks every DIVISOR edges, wrap on 11 -> 0.
        @(negedge clock);
        resetn  = 1'b1;
        m_phase = 0;
        m_count = 0;
        drive_and_push(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (79) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // Count down from zero: 0 -> 11 with wrap, then 10.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Saturating load, then a load that coincides with a tick edge.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd200);
        run_to_tick_edge(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Clear on the tick edge suppresses that tick and restarts the divider.
        run_to_tick_edge(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        repeat (13) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // Asynchronous reset while holding count 7.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd7);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        check("count_before_reset", 32'(count), 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clock);
        #1;
        check_all_zero("reset_hold");
        @(negedge clock);
        resetn  = 1'b1;
        m_phase = 0;
        m_count = 0;
        drive_and_push(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // Disabled across three ticks: count frozen, ticks continue.
        repeat (3 * DIVISOR) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Display digits at count 11.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd11);
        @(posedge clock);
        #2;
`ifdef TICK_MOD_COUNTER_BCD_EN
        check("digits11_hi", 32'(digit_hi), 32'd1);
        check("digits11_lo", 32'(digit_lo), 32'd1);
`else
        check("digits11_hi", 32'(digit_hi), 32'd0);
        check("digits11_lo", 32'(digit_lo), 32'hB);
`endif

        // Randomised traffic.
        up_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) up_r = ~up_r;
            lv_r = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, up_r,
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, lv_r);
        end

        repeat (3) @(posedge clock);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_mod_counter.md
Name: tick_mod_counter

Overview:
- Parametrised successor to the fixed 30 Hz divider and count-to-30 pair.
- Combines a programmable tick generator (CLK_HZ/TICK_HZ) with a modulo-MOD counter.
- The counter supports enable, up/down direction, synchronous clear and saturating load, and emits a single-cycle wrap pulse.
- Drives game frame timing and provides two 4-bit digit outputs for the seven-segment decoders.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 30, tick rate in Hz. DIVISOR = CLK_HZ/TICK_HZ (integer division), must be >= 2.
- MOD, 30, counter modulus. Count range is 0..MOD-1, with 2 <= MOD <= 256.
- DIV_W, 26, divider register width. Must satisfy 2^DIV_W >= DIVISOR.
- CNT_W, 8, count width. Must satisfy 2^CNT_W >= MOD.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  counter advances on a tick only while 1; the divider always runs
- up  in  1  direction: 1 = increment, 0 = decrement
- sclear  in  1  synchronous clear of both divider and counter
- load  in  1  synchronous load of load_val into the counter
- load_val  in  CNT_W  load value
- tick  out  1  one-cycle pulse at TICK_HZ
- count  out  CNT_W  current count
- wrap  out  1  one-cycle pulse when the count wraps
- digit_lo  out  4  low display digit
- digit_hi  out  4  high display digit

Behaviour:
- Reset (resetn=0, asynchronous): div=0, tick=0, count=0, wrap=0, digit_lo=0, digit_hi=0. Outputs stay held while resetn is low. Counting resumes from zero on the first edge after release, regardless of any state before reset.
- Divider (evaluated each clock edge):
  - If sclear: div<=0.
  - Else if div==DIVISOR-1: div<=0.
  - Else: div<=div+1.
- tick is registered. It is 1 for exactly the one cycle following the edge where div==DIVISOR-1 and sclear=0. The tick period is exactly DIVISOR clocks. The first tick after reset appears DIVISOR edges after release.
- Counter priority, highest first, evaluated at each edge:
  1. sclear: count<=0, wrap<=0.
  2. load: count<=min(load_val, MOD-1), wrap<=0. An out-of-range load saturates to MOD-1.
  3. Tick condition (div==DIVISOR-1) with enable=1:
     - up=1: if count==MOD-1 then count<=0 and wrap<=1, else count+1.
     - up=0: if count==0 then count<=MOD-1 and wrap<=1, else count-1.
  4. Otherwise: count holds, wrap<=0.
- count, tick and wrap all update on the same edge. Latency from the tick condition to the new count is 1 clock.
- wrap is never high for more than one consecutive cycle.
- A load or sclear coinciding with a tick takes priority, and that tick's advance is lost. tick itself still pulses unless sclear is asserted.
- Changing direction mid-sequence takes effect on the next tick with no extra latency.
- enable=0 with tick: count holds, wrap stays 0, tick still pulses.
- All arithmetic is unsigned at CNT_W. The counter never leaves 0..MOD-1.
- digit_lo/digit_hi update on the same edge as count. Their encoding is set by the optional feature below.

Optional Feature:
- Macro: TICK_MOD_COUNTER_BCD_EN.
- Defined: digits are decimal. digit_lo = count mod 10 and digit_hi = (count/10) mod 10, both registered and updated with count. Requires MOD <= 100; elaboration fails otherwise.
- Undefined: digits are hex. digit_lo = count[3:0] and digit_hi = count[7:4], zero-extended when CNT_W < 8.

Test Plan (bench params CLK_HZ=60, TICK_HZ=10, MOD=12, CNT_W=8, DIV_W=4):
1. Release reset with enable=1, up=1 -> tick at cycles 6, 12, 18… (1 cycle wide). count goes 1, 2, … 11, 0 with wrap=1 only on the 11->0 cycle.
2. With up=0 from count=0, tick -> count=11 and wrap=1. Next tick -> count=10 and wrap=0.
3. load=1, load_val=200 -> count=11. load_val=5 asserted on a tick edge -> count=5 and no advance; tick still pulses.
4. sclear on the edge where div=5 -> no tick, count=0, and the next tick arrives 6 cycles later. resetn pulsed low mid-count=7 -> all outputs 0 immediately, without waiting for a clock edge.
5. enable=0 across 3 ticks -> count frozen, wrap=0, tick keeps pulsing.
6. Count=11: BCD_EN defined -> digit_hi=1, digit_lo=1. Undefined -> digit_hi=0, digit_lo=0xB.
